// File: rtl/fft4_stream_engine.sv
// fft4_stream_engine
//   4-point complex DFT engine. A frame of four {re,im} samples is accepted
//   through a valid/ready handshake. The engine computes the forward or inverse
//   transform in one cycle, then scales and saturates the result. The four bins
//   are then written out as result words with frame-indexed addresses.
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   en                  global enable; low freezes all state
//   in_valid/in_ready   frame handshake (accept only in IDLE)
//   in_point0..3        samples x0..x3, {re[DW-1:0], im[DW-1:0]}
//   inverse             sampled with the frame: 0 forward, 1 inverse
//   mem_stall           result RAM busy; current bin is held
//   data_out/address/we result word, {frame_idx, bin} address, write strobe
//   done/ovf            pulse with the bin-3 write; ovf = frame saturated
module fft4_stream_engine #(
  parameter int DW     = 16,
  parameter int ADDR_W = 32,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   in_point0,
  input  logic [2*DW-1:0]   in_point1,
  input  logic [2*DW-1:0]   in_point2,
  input  logic [2*DW-1:0]   in_point3,
  input  logic              inverse,
  input  logic              mem_stall,
  output logic [2*DW-1:0]   data_out,
  output logic [ADDR_W-1:0] address,
  output logic              we,
  output logic              done,
  output logic              ovf
);

  localparam int IW = DW + 2;
  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (DW - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   r_state;
  logic signed [DW-1:0]     r_xre [4];
  logic signed [DW-1:0]     r_xim [4];
  logic                     r_inv;
  logic [2*DW-1:0]          r_word [4];
  logic                     r_frame_ovf;
  logic [1:0]               r_bin;
  logic [ADDR_W-3:0]        r_frame_idx;

  logic signed [IW-1:0]     w_are, w_aim, w_bre, w_bim, w_cre, w_cim, w_dre, w_dim;
  logic signed [IW-1:0]     w_re [4];
  logic signed [IW-1:0]     w_im [4];
  logic [DW:0]              w_sre [4];
  logic [DW:0]              w_sim [4];
  logic [2*DW-1:0]          w_word [4];
  logic                     w_ovf;
  logic                     w_accept;

  // Returns {clipped, value}: floor shift, then clamp to the DW-bit range.
  function automatic logic [DW:0] saturate(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_MAX)
      saturate = {1'b1, SAT_MAX[DW-1:0]};
    else if (s < SAT_MIN)
      saturate = {1'b1, SAT_MIN[DW-1:0]};
    else
      saturate = {1'b0, s[DW-1:0]};
  endfunction

  always_comb begin
    w_are = IW'(r_xre[0]) + IW'(r_xre[2]);
    w_aim = IW'(r_xim[0]) + IW'(r_xim[2]);
    w_bre = IW'(r_xre[0]) - IW'(r_xre[2]);
    w_bim = IW'(r_xim[0]) - IW'(r_xim[2]);
    w_cre = IW'(r_xre[1]) + IW'(r_xre[3]);
    w_cim = IW'(r_xim[1]) + IW'(r_xim[3]);
    w_dre = IW'(r_xre[1]) - IW'(r_xre[3]);
    w_dim = IW'(r_xim[1]) - IW'(r_xim[3]);
    w_re[0] = w_are + w_cre;
    w_im[0] = w_aim + w_cim;
    w_re[2] = w_are - w_cre;
    w_im[2] = w_aim - w_cim;
    // j*d = (-d_im, d_re); forward X1 = b - j*d, inverse swaps X1/X3.
    if (!r_inv) begin
      w_re[1] = w_bre + w_dim;
      w_im[1] = w_bim - w_dre;
      w_re[3] = w_bre - w_dim;
      w_im[3] = w_bim + w_dre;
    end else begin
      w_re[1] = w_bre - w_dim;
      w_im[1] = w_bim + w_dre;
      w_re[3] = w_bre + w_dim;
      w_im[3] = w_bim - w_dre;
    end
    w_ovf = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_sre[i]  = saturate(w_re[i]);
      w_sim[i]  = saturate(w_im[i]);
      w_word[i] = {w_sre[i][DW-1:0], w_sim[i][DW-1:0]};
      w_ovf     = w_ovf | w_sre[i][DW] | w_sim[i][DW];
    end
  end

  assign in_ready = (r_state == IDLE) & en & ~reset;
  assign w_accept = in_valid & in_ready;
  assign we       = (r_state == OUT) & en & ~mem_stall;
  assign done     = we & (r_bin == 2'd3);
  assign ovf      = done & r_frame_ovf;
  assign data_out = (r_state == OUT) ? r_word[r_bin] : '0;
  assign address  = (r_state == OUT) ? {r_frame_idx, r_bin} : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_inv       <= 1'b0;
      r_frame_ovf <= 1'b0;
      r_bin       <= '0;
      r_frame_idx <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_xre[i]  <= '0;
        r_xim[i]  <= '0;
        r_word[i] <= '0;
      end
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_xre[0] <= in_point0[2*DW-1:DW];
            r_xim[0] <= in_point0[DW-1:0];
            r_xre[1] <= in_point1[2*DW-1:DW];
            r_xim[1] <= in_point1[DW-1:0];
            r_xre[2] <= in_point2[2*DW-1:DW];
            r_xim[2] <= in_point2[DW-1:0];
            r_xre[3] <= in_point3[2*DW-1:DW];
            r_xim[3] <= in_point3[DW-1:0];
            r_inv    <= inverse;
            r_state  <= CALC;
          end
        end
        CALC: begin
          for (int unsigned i = 0; i < 4; i++) r_word[i] <= w_word[i];
          r_frame_ovf <= w_ovf;
          r_bin       <= '0;
          r_state     <= OUT;
        end
        OUT: begin
          if (!mem_stall) begin
            if (r_bin == 2'd3) begin
              r_frame_idx <= r_frame_idx + 1'b1;
              r_bin       <= '0;
              r_state     <= IDLE;
            end else begin
              r_bin <= r_bin + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stream_engine.sv
// tb_fft4_stream_engine
//   Directed bench for fft4_stream_engine (DW=16, ADDR_W=32). A second
//   instance with SHIFT=2 shares all inputs and is checked on the
//   saturation frame.
module tb_fft4_stream_engine;

  logic        clk = 1'b0;
  logic        reset, en, in_valid, inverse, mem_stall;
  logic [31:0] p0, p1, p2, p3;
  logic        in_ready, we, done, ovf;
  logic [31:0] data_out, address;
  logic        in_ready2, we2, done2, ovf2;
  logic [31:0] data_out2, address2;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  fft4_stream_engine #(.DW(16), .ADDR_W(32), .SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_point0(p0), .in_point1(p1), .in_point2(p2), .in_point3(p3),
    .inverse(inverse), .mem_stall(mem_stall), .data_out(data_out),
    .address(address), .we(we), .done(done), .ovf(ovf)
  );

  fft4_stream_engine #(.DW(16), .ADDR_W(32), .SHIFT(2)) u_dut_s2 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready2),
    .in_point0(p0), .in_point1(p1), .in_point2(p2), .in_point3(p3),
    .inverse(inverse), .mem_stall(mem_stall), .data_out(data_out2),
    .address(address2), .we(we2), .done(done2), .ovf(ovf2)
  );

  function automatic logic [31:0] W(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic logic [3:0][31:0] F(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts one frame; returns with the engine in CALC.
  task automatic send(input logic [31:0] x0, x1, x2, x3, input logic inv);
    chk("ready_before_send", in_ready, 1);
    p0 = x0; p1 = x1; p2 = x2; p3 = x3;
    inverse  = inv;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    inverse = 1'b0;
    chk("ready_in_calc", in_ready, 0);
  endtask

  task automatic expect_bins(input logic [3:0][31:0] w, input logic [31:0] base,
                             input int from, input logic exp_ovf, input bit s2,
                             input logic [3:0][31:0] w2, input logic exp_ovf2);
    for (int b = from; b < 4; b++) begin
      chk($sformatf("we b%0d", b), we, 1);
      chk($sformatf("data b%0d", b), data_out, w[b]);
      chk($sformatf("addr b%0d", b), address, base + 32'(b));
      chk($sformatf("done b%0d", b), done, b == 3);
      chk($sformatf("ovf b%0d", b), ovf, (b == 3) ? exp_ovf : 1'b0);
      if (s2) begin
        chk($sformatf("s2_data b%0d", b), data_out2, w2[b]);
        chk($sformatf("s2_done b%0d", b), done2, b == 3);
        chk($sformatf("s2_ovf b%0d", b), ovf2, (b == 3) ? exp_ovf2 : 1'b0);
      end
      tick;
    end
    chk("we_after_frame", we, 0);
    chk("ready_after_frame", in_ready, 1);
  endtask

  logic [3:0][31:0] f_imp, f_x1f, f_x1i, f_sat, f_sat2, f_mix, none;

  initial begin
    f_imp  = F(W(100, 0), W(100, 0), W(100, 0), W(100, 0));
    f_x1f  = F(W(100, 0), W(0, -100), W(-100, 0), W(0, 100));
    f_x1i  = F(W(100, 0), W(0, 100), W(-100, 0), W(0, -100));
    f_sat  = F(W(32767, 0), W(0, 0), W(0, 0), W(0, 0));
    f_sat2 = F(W(32767, 0), W(0, 0), W(0, 0), W(0, 0));
    f_mix  = F(W(16, 20), W(-8, 0), W(-4, -4), W(0, -8));
    none   = '0;

    // Reset state, with a frame offered while reset is high.
    reset = 1'b1; en = 1'b1; in_valid = 1'b1; inverse = 1'b0; mem_stall = 1'b0;
    p0 = W(100, 0); p1 = '0; p2 = '0; p3 = '0;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", data_out, 0);
    chk("rst_addr", address, 0);
    chk("rst_s2_we", we2, 0);
    chk("rst_s2_addr", address2, 0);
    tick;
    in_valid = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    chk("s2_ready_after_rst", in_ready2, 1);

    // 1. impulse at x0, forward
    send(W(100, 0), '0, '0, '0, 1'b0);
    tick;
    expect_bins(f_imp, 32'd0, 0, 1'b0, 1'b0, none, 1'b0);

    // 2. impulse at x1, forward then inverse
    send('0, W(100, 0), '0, '0, 1'b0);
    tick;
    expect_bins(f_x1f, 32'd4, 0, 1'b0, 1'b0, none, 1'b0);
    send('0, W(100, 0), '0, '0, 1'b1);
    tick;
    expect_bins(f_x1i, 32'd8, 0, 1'b0, 1'b0, none, 1'b0);

    // 3. full-scale DC: SHIFT=0 clips, SHIFT=2 does not
    send(W(32767, 0), W(32767, 0), W(32767, 0), W(32767, 0), 1'b0);
    tick;
    expect_bins(f_sat, 32'd12, 0, 1'b1, 1'b1, f_sat2, 1'b0);

    // 4. stall for 3 cycles during bin 1
    send(W(1, 2), W(3, 4), W(5, 6), W(7, 8), 1'b0);
    tick;
    expect_bins(f_mix, 32'd16, 0, 1'b0, 1'b0, none, 1'b0);
    // expect_bins ran to the end; replay the stall scenario on a fresh frame
    send(W(1, 2), W(3, 4), W(5, 6), W(7, 8), 1'b0);
    tick;
    chk("stall_b0_addr", address, 32'd20);
    tick;
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_we c%0d", i), we, 0);
      chk($sformatf("stall_done c%0d", i), done, 0);
      chk($sformatf("stall_addr c%0d", i), address, 32'd21);
      chk($sformatf("stall_data c%0d", i), data_out, f_mix[1]);
      tick;
    end
    mem_stall = 1'b0;
    #1;
    expect_bins(f_mix, 32'd20, 1, 1'b0, 1'b0, none, 1'b0);

    // 5. enable dropped in CALC and in OUT, then in IDLE with a frame offered
    send('0, W(100, 0), '0, '0, 1'b0);
    en = 1'b0;
    #1;
    chk("en0_calc_we", we, 0);
    chk("en0_calc_ready", in_ready, 0);
    tick;
    tick;
    en = 1'b1;
    #1;
    chk("en1_calc_we", we, 0);
    tick;
    chk("en_b0_data", data_out, f_x1f[0]);
    chk("en_b0_addr", address, 32'd24);
    tick;
    en = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("en0_out_we c%0d", i), we, 0);
      chk($sformatf("en0_out_data c%0d", i), data_out, f_x1f[1]);
      chk($sformatf("en0_out_addr c%0d", i), address, 32'd25);
      tick;
    end
    en = 1'b1;
    #1;
    expect_bins(f_x1f, 32'd24, 1, 1'b0, 1'b0, none, 1'b0);
    en = 1'b0;
    in_valid = 1'b1;
    p0 = W(100, 0);
    #1;
    chk("en0_idle_ready", in_ready, 0);
    tick;
    tick;
    chk("en0_idle_we", we, 0);
    in_valid = 1'b0;
    p0 = '0;
    en = 1'b1;
    #1;
    chk("en1_idle_ready", in_ready, 1);

    // 6. reset during bin 2, then restart from address 0
    send(W(1, 2), W(3, 4), W(5, 6), W(7, 8), 1'b0);
    tick;
    tick;
    tick;
    chk("pre_rst_we", we, 1);
    chk("pre_rst_addr", address, 32'd30);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_ready", in_ready, 0);
    tick;
    reset = 1'b0;
    #1;
    send(W(100, 0), '0, '0, '0, 1'b0);
    tick;
    expect_bins(f_imp, 32'd0, 0, 1'b0, 1'b0, none, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
